// File: rtl/rede_taylor_pkg.sv
// Shared definitions for the rede_taylor_core slice.
// Holds the sequencing states, bus widths, the port address this core
// answers on, the default exp(x) coefficients and the 28-bit saturation helper.
package rede_taylor_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int IN_W   = 19;
  localparam int OUT_W  = 28;
  localparam int PORT_W = 4;
  localparam int PROD_W = IN_W + OUT_W;

  localparam logic [PORT_W-1:0] PORT_ID = 4'd1;

  // Default coefficients in Q.10: 1.0, 1.0, 0.5, ~1/6 (truncated exp(x)).
  localparam int unsigned             FRAC_DEF = 10;
  localparam logic signed [OUT_W-1:0] C0_DEF   = 28'sd1024;
  localparam logic signed [OUT_W-1:0] C1_DEF   = 28'sd1024;
  localparam logic signed [OUT_W-1:0] C2_DEF   = 28'sd512;
  localparam logic signed [OUT_W-1:0] C3_DEF   = 28'sd171;

  localparam logic signed [PROD_W:0] SAT_MAX = 48'sd134217727;
  localparam logic signed [PROD_W:0] SAT_MIN = -48'sd134217728;

  // Clamp a wide signed sum into the signed 28-bit result range.
  function automatic logic signed [OUT_W-1:0] sat28(input logic signed [PROD_W:0] v);
    logic signed [OUT_W-1:0] r;
    if (v > SAT_MAX) begin
      r = 28'sh7FFFFFF;
    end else if (v < SAT_MIN) begin
      r = -28'sd134217728;
    end else begin
      r = v[OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/rede_taylor_core_mac.sv
// taylor_mac: one Horner step, purely combinational.
//   acc (in, 28 signed)  running accumulator, Q.FRAC
//   x   (in, 19 signed)  sample, Q.FRAC
//   c   (in, 28 signed)  coefficient added in this step, Q.FRAC
//   y   (out, 28 signed) sat28(((acc*x) >>> FRAC) + c)
module taylor_mac
  import rede_taylor_pkg::*;
#(
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic signed [OUT_W-1:0] acc,
  input  logic signed [IN_W-1:0]  x,
  input  logic signed [OUT_W-1:0] c,
  output logic signed [OUT_W-1:0] y
);

  logic signed [PROD_W-1:0] prod_s;
  logic signed [PROD_W-1:0] shifted_s;
  logic signed [PROD_W:0]   sum_s;

  // Full-width product, floor-rescale, add coefficient one bit wider, then clamp.
  always_comb begin
    prod_s    = PROD_W'(acc) * PROD_W'(x);
    shifted_s = prod_s >>> FRAC;
    sum_s     = $signed({shifted_s[PROD_W-1], shifted_s})
              + $signed({{(PROD_W + 1 - OUT_W){c[OUT_W-1]}}, c});
    y         = sat28(sum_s);
  end

endmodule

// File: rtl/rede_taylor_core.sv
// rede_taylor_core: evaluates y = C0 + C1*x + C2*x^2 + C3*x^3 by Horner's
// method with a single shared multiply-add, one sample at a time.
//   clk    (in)             rising-edge clock
//   rst    (in)             synchronous active-high reset
//   io_in  (in, 19 signed)  shared sample bus, captured at the end of REQ
//   io_out (out, 28 signed) last result, updated on entry to OUT
//   req_in (out, 4)         PORT_ID while requesting a sample, else 0
//   out_en (out, 4)         PORT_ID for the single cycle io_out is fresh, else 0
module rede_taylor_core
  import rede_taylor_pkg::*;
#(
  parameter int unsigned             FRAC = FRAC_DEF,
  parameter logic signed [OUT_W-1:0] C0   = C0_DEF,
  parameter logic signed [OUT_W-1:0] C1   = C1_DEF,
  parameter logic signed [OUT_W-1:0] C2   = C2_DEF,
  parameter logic signed [OUT_W-1:0] C3   = C3_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [IN_W-1:0]   io_in,
  output logic signed [OUT_W-1:0]  io_out,
  output logic [PORT_W-1:0]        req_in,
  output logic [PORT_W-1:0]        out_en
);

  state_e                  state_q, state_d;
  logic [1:0]              k_q, k_d;
  logic signed [IN_W-1:0]  x_q, x_d;
  logic signed [OUT_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] io_out_q, io_out_d;
  logic [PORT_W-1:0]       req_in_q, req_in_d;
  logic [PORT_W-1:0]       out_en_q, out_en_d;

  logic signed [OUT_W-1:0] coef_s;
  logic signed [OUT_W-1:0] mac_y_s;

  // Coefficient for the current Horner step (k counts 2,1,0).
  always_comb begin
    case (k_q)
      2'd2:    coef_s = C2;
      2'd1:    coef_s = C1;
      2'd0:    coef_s = C0;
      default: coef_s = C3;
    endcase
  end

  taylor_mac #(
    .FRAC (FRAC)
  ) u_mac (
    .acc (acc_q),
    .x   (x_q),
    .c   (coef_s),
    .y   (mac_y_s)
  );

  // Sequencer: next state, datapath loads and next values of the port strobes.
  // The strobes are flops, so each is decided one edge ahead. Coming out of
  // reset the REQ state first spends an edge raising req_in; REQ only samples
  // io_in once the request has actually been visible on the bus.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    x_d      = x_q;
    acc_d    = acc_q;
    io_out_d = io_out_q;
    req_in_d = 4'd0;
    out_en_d = 4'd0;
    case (state_q)
      REQ: begin
        if (req_in_q == PORT_ID) begin
          x_d     = io_in;
          acc_d   = C3;
          k_d     = 2'd2;
          state_d = CALC;
        end else begin
          req_in_d = PORT_ID;
        end
      end
      CALC: begin
        acc_d = mac_y_s;
        if (k_q == 2'd0) begin
          io_out_d = mac_y_s;
          out_en_d = PORT_ID;
          state_d  = OUT;
        end else begin
          k_d = k_q - 2'd1;
        end
      end
      OUT: begin
        req_in_d = PORT_ID;
        state_d  = REQ;
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REQ;
      k_q      <= 2'd0;
      x_q      <= 19'sd0;
      acc_q    <= 28'sd0;
      io_out_q <= 28'sd0;
      req_in_q <= 4'd0;
      out_en_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      io_out_q <= io_out_d;
      req_in_q <= req_in_d;
      out_en_q <= out_en_d;
    end
  end

  assign io_out = io_out_q;
  assign req_in = req_in_q;
  assign out_en = out_en_q;

endmodule

// File: tb/tb_rede_taylor_core.sv
// Directed bench for rede_taylor_core with hand-computed expected results.
module tb_rede_taylor_core;

  logic               clk;
  logic               rst;
  logic signed [18:0] io_in;
  logic signed [27:0] io_out;
  logic [3:0]         req_in;
  logic [3:0]         out_en;

  int total;
  int bad;
  int cyc;
  int last_pulse;
  logic signed [31:0] prev_out;

  rede_taylor_core dut (
    .clk    (clk),
    .rst    (rst),
    .io_in  (io_in),
    .io_out (io_out),
    .req_in (req_in),
    .out_en (out_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called one cycle into REQ (req_in already visible); leaves the bench
  // one cycle into the following REQ.
  task automatic run_sample(input string tag, input logic signed [18:0] xv,
                            input logic signed [31:0] exp_y, input bit scramble);
    check({tag, ".req"}, 32'(req_in), 32'sd1);
    check({tag, ".oen_req"}, 32'(out_en), 32'sd0);
    io_in = xv;
    step();
    for (int i = 0; i < 3; i++) begin
      check({tag, ".calc_req"}, 32'(req_in), 32'sd0);
      check({tag, ".calc_oen"}, 32'(out_en), 32'sd0);
      check({tag, ".hold"}, 32'(io_out), prev_out);
      if (scramble) io_in = 19'($urandom);
      step();
    end
    check({tag, ".oen"}, 32'(out_en), 32'sd1);
    check({tag, ".out_req"}, 32'(req_in), 32'sd0);
    check({tag, ".y"}, 32'(io_out), exp_y);
    if (last_pulse >= 0) check({tag, ".period"}, 32'(cyc - last_pulse), 32'sd5);
    last_pulse = cyc;
    prev_out = exp_y;
    if (scramble) io_in = 19'($urandom);
    step();
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    last_pulse = -1;
    prev_out = 32'sd0;
    rst = 1'b1;
    io_in = 19'sd0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst.io_out", 32'(io_out), 32'sd0);
      check("rst.req_in", 32'(req_in), 32'sd0);
      check("rst.out_en", 32'(out_en), 32'sd0);
    end
    rst = 1'b0;
    step();
    check("first_req", 32'(req_in), 32'sd1);

    run_sample("x0", 19'sd0, 32'sd1024, 1'b0);
    run_sample("x1p0", 19'sd1024, 32'sd2731, 1'b0);
    run_sample("xm1p0", -19'sd1024, 32'sd341, 1'b0);
    run_sample("xmax", 19'sd262143, 32'sd134217727, 1'b0);
    run_sample("xmin", -19'sd262144, -32'sd134217728, 1'b0);
    run_sample("xscr", 19'sd1024, 32'sd2731, 1'b1);

    // Reset during the second CALC cycle abandons the computation.
    check("abort.req", 32'(req_in), 32'sd1);
    io_in = -19'sd1024;
    step();
    check("abort.calc1", 32'(req_in), 32'sd0);
    step();
    check("abort.calc2", 32'(out_en), 32'sd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort.io_out", 32'(io_out), 32'sd0);
      check("abort.req_in", 32'(req_in), 32'sd0);
      check("abort.out_en", 32'(out_en), 32'sd0);
    end
    rst = 1'b0;
    prev_out = 32'sd0;
    last_pulse = -1;
    step();
    check("restart.req", 32'(req_in), 32'sd1);
    run_sample("rx1", -19'sd1024, 32'sd341, 1'b0);
    run_sample("rx2", 19'sd1024, 32'sd2731, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
